// File: rtl/cache_control.sv
// L1 cache controller FSM: hit service, dirty-victim writeback and line allocation.
// Optional performance counters (hit_count/miss_count) are built when CACHE_PERF_CNT_EN is defined.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 hit,
    input  logic                 victim_dirty,
    input  logic                 pmem_resp,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 pmem_addr_sel,
    output logic                 datain_sel,
    output logic                 load_data,
    output logic                 load_tag,
    output logic                 load_valid,
    output logic                 load_dirty,
    output logic                 load_lru,
    output logic                 dirty_in,
    output logic [1:0]           state_dbg
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WB    = 2'd1;
    localparam logic [1:0] S_ALLOC = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       req;

    // Handshake: the CPU holds mem_read/mem_write until mem_resp; pmem_read/pmem_write
    // are held until the single-cycle pmem_resp pulse and drop the following cycle.
    assign req       = mem_read | mem_write;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are forced low while rst is high so no strobe escapes during reset.
    always_comb begin
        state_next    = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        datain_sel    = 1'b0;
        load_data     = 1'b0;
        load_tag      = 1'b0;
        load_valid    = 1'b0;
        load_dirty    = 1'b0;
        load_lru      = 1'b0;
        dirty_in      = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (hit) begin
                            mem_resp = 1'b1;
                            load_lru = 1'b1;
                            // A simultaneous read+write is serviced as a write.
                            if (mem_write) begin
                                load_data  = 1'b1;
                                load_dirty = 1'b1;
                                dirty_in   = 1'b1;
                            end
                        end else begin
                            state_next = victim_dirty ? S_WB : S_ALLOC;
                        end
                    end
                end
                S_WB: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        state_next = S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_data  = 1'b1;
                        datain_sel = 1'b1;
                        load_tag   = 1'b1;
                        load_valid = 1'b1;
                        load_dirty = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic hit_inc;
    logic miss_inc;

    assign hit_inc  = (state == S_IDLE) && req && hit && mem_resp;
    assign miss_inc = (state == S_IDLE) && (state_next != S_IDLE);

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_WIDTH'(1);
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_WIDTH'(1);
            end
        end
    end
`else
    logic [CNT_WIDTH-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: randomized transactions scored against a per-cycle expected trace
// built from transaction-level rules (decision cycle, writeback, allocate, refill hit).
module tb_cache_control;

    localparam int CW = 2;

    // Output vector bit positions (bench-side packing of DUT outputs).
    localparam logic [10:0] O_RESP   = 11'h400;
    localparam logic [10:0] O_PRD    = 11'h200;
    localparam logic [10:0] O_PWR    = 11'h100;
    localparam logic [10:0] O_ASEL   = 11'h080;
    localparam logic [10:0] O_DSEL   = 11'h040;
    localparam logic [10:0] O_LDATA  = 11'h020;
    localparam logic [10:0] O_LTAG   = 11'h010;
    localparam logic [10:0] O_LVAL   = 11'h008;
    localparam logic [10:0] O_LDIRTY = 11'h004;
    localparam logic [10:0] O_LLRU   = 11'h002;
    localparam logic [10:0] O_DIN    = 11'h001;

    logic clk, rst;
    logic mem_read, mem_write, hit, victim_dirty, pmem_resp;
    logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, datain_sel;
    logic load_data, load_tag, load_valid, load_dirty, load_lru, dirty_in;
    logic [1:0] state_dbg;
`ifdef CACHE_PERF_CNT_EN
    logic [CW-1:0] hit_count, miss_count;
`endif

    logic [10:0] out_vec;
    logic [10:0] exp_q[$];
    int vec_cnt  = 0;
    int fail_cnt = 0;
    int model_hits   = 0;
    int model_misses = 0;
    int cnt_max = (1 << CW) - 1;

    assign out_vec = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, datain_sel,
                      load_data, load_tag, load_valid, load_dirty, load_lru, dirty_in};

    cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .hit(hit),
        .victim_dirty(victim_dirty), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .datain_sel(datain_sel),
        .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
        .load_dirty(load_dirty), .load_lru(load_lru), .dirty_in(dirty_in),
        .state_dbg(state_dbg)
`ifdef CACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, score outputs at the falling edge, return at posedge+1.
    task automatic run_cycle(input logic rd, input logic wr, input logic h, input logic vd,
                             input logic pr, input logic [10:0] exp, input string tag);
        logic [10:0] e;
        mem_read = rd; mem_write = wr; hit = h; victim_dirty = vd; pmem_resp = pr;
        exp_q.push_back(exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq(tag, {5'b0, out_vec}, {5'b0, e});
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int v);
        return (v < cnt_max) ? v + 1 : v;
    endfunction

    // kind: 0 read, 1 write, 2 read+write. A miss costs one decision cycle, m writeback
    // cycles if the victim is dirty, n allocate cycles, then one hit cycle.
    task automatic do_txn(input int kind, input bit is_hit, input bit vd, input int m,
                          input int n, input bit drop);
        logic rd, wr;
        logic [10:0] hit_exp, last;
        rd = (kind != 1);
        wr = (kind != 0);
        hit_exp = O_RESP | O_LLRU | (wr ? (O_LDATA | O_LDIRTY | O_DIN) : 11'h000);
        if (is_hit) begin
            run_cycle(rd, wr, 1'b1, 1'($urandom), 1'($urandom), hit_exp, "hit");
            model_hits = sat_inc(model_hits);
        end else begin
            run_cycle(rd, wr, 1'b0, vd, 1'($urandom), 11'h000, "decide");
            model_misses = sat_inc(model_misses);
            if (drop) begin
                rd = 1'b0;
                wr = 1'b0;
            end
            if (vd) begin
                for (int i = 0; i < m; i++)
                    run_cycle(rd, wr, 1'($urandom), 1'($urandom), (i == m - 1),
                              O_PWR | O_ASEL, "writeback");
            end
            for (int i = 0; i < n; i++) begin
                last = (i == n - 1) ? (O_LDATA | O_LTAG | O_LVAL | O_LDIRTY | O_DSEL) : 11'h000;
                run_cycle(rd, wr, 1'($urandom), 1'($urandom), (i == n - 1),
                          O_PRD | last, "allocate");
            end
            if (drop) begin
                run_cycle(1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 11'h000, "dropped_idle");
            end else begin
                run_cycle(rd, wr, 1'b1, 1'($urandom), 1'($urandom), hit_exp, "refill_hit");
                model_hits = sat_inc(model_hits);
            end
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef CACHE_PERF_CNT_EN
        check_eq({tag, "_hits"}, 16'(hit_count), 16'(model_hits));
        check_eq({tag, "_misses"}, 16'(miss_count), 16'(model_misses));
`else
        check_eq({tag, "_no_cnt_state"}, {14'b0, state_dbg}, 16'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        mem_read = 1'b1; mem_write = 1'b0; hit = 1'b1; victim_dirty = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        check_eq("reset_outputs", {5'b0, out_vec}, 16'd0);
        check_eq("reset_state", {14'b0, state_dbg}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset asserted mid-cycle while allocating: pmem_read must drop before the next edge.
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, "rm_decide");
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_PRD, "rm_alloc");
        #1;
        check_eq("rm_pre_pmem_read", {15'b0, pmem_read}, 16'd1);
        pmem_resp = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check_eq("rm_async_drop", {5'b0, out_vec}, 16'd0);
        @(posedge clk);
        #1;
        check_eq("rm_held", {5'b0, out_vec}, 16'd0);
        mem_read = 1'b0; pmem_resp = 1'b0;
        rst = 1'b0;
        model_hits = 0;
        model_misses = 0;
        #1;
        check_eq("rm_state_idle", {14'b0, state_dbg}, 16'd0);
        check_eq("rm_outputs_idle", {5'b0, out_vec}, 16'd0);

        // Directed: read hit, write hit, clean miss (N=5), dirty miss, read+write hit.
        do_txn(0, 1'b1, 1'b0, 0, 0, 1'b0);
        do_txn(1, 1'b1, 1'b0, 0, 0, 1'b0);
        do_txn(0, 1'b0, 1'b0, 0, 5, 1'b0);
        do_txn(1, 1'b0, 1'b1, 3, 2, 1'b0);
        do_txn(2, 1'b1, 1'b0, 0, 0, 1'b0);
        check_counters("directed");
        for (int i = 0; i < 4; i++) do_txn(0, 1'b1, 1'b0, 0, 0, 1'b0);
        check_counters("saturate");

        // Randomized transactions with idle gaps carrying stray pmem_resp pulses.
        for (int t = 0; t < 60; t++) begin
            do_txn(int'($urandom_range(0, 2)), 1'($urandom_range(0, 2) == 0), 1'($urandom),
                   int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                   1'($urandom_range(0, 4) == 0));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                run_cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 11'h000, "idle");
        end
        check_counters("random");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
